// File: rtl/tdes_pkg.sv
// Shared types, sizes and EDE pass schedule for the Triple-DES round sequencer.
package tdes_pkg;

   localparam int unsigned NUM_ROUNDS = 16;
   localparam int unsigned NUM_PASSES = 3;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned RN_W       = 5;
   localparam int unsigned KEY_W      = 2;
   localparam int unsigned PASS_W     = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROUND,
      ST_PASS_END,
      ST_DONE
   } state_t;

   localparam logic [KEY_W-1:0] KEY1 = 2'd0;
   localparam logic [KEY_W-1:0] KEY2 = 2'd1;
   localparam logic [KEY_W-1:0] KEY3 = 2'd2;

   // Key per pass, pass 0 in the low field: encrypt K1,K2,K3 / decrypt K3,K2,K1
   localparam logic [3*KEY_W-1:0] ENC_KEYS = {KEY3, KEY2, KEY1};
   localparam logic [3*KEY_W-1:0] DEC_KEYS = {KEY1, KEY2, KEY3};

   // Direction per pass, bit 0 = pass 0, 1 = DES decrypt: encrypt E,D,E / decrypt D,E,D
   localparam logic [NUM_PASSES-1:0] ENC_DIRS = 3'b010;
   localparam logic [NUM_PASSES-1:0] DEC_DIRS = 3'b101;

   // Key wrapper selected for a given pass of the block
   function automatic logic [KEY_W-1:0] sched_key(input logic dec, input logic [PASS_W-1:0] pass);
      logic [3*KEY_W-1:0] tbl;
      logic [KEY_W-1:0]   key;
      tbl = dec ? DEC_KEYS : ENC_KEYS;
      case (pass)
         2'd0:    key = tbl[1:0];
         2'd1:    key = tbl[3:2];
         default: key = tbl[5:4];
      endcase
      return key;
   endfunction

   // DES direction of a given pass of the block
   function automatic logic sched_dec(input logic dec, input logic [PASS_W-1:0] pass);
      logic [NUM_PASSES-1:0] tbl;
      logic                  d;
      tbl = dec ? DEC_DIRS : ENC_DIRS;
      case (pass)
         2'd0:    d = tbl[0];
         2'd1:    d = tbl[1];
         default: d = tbl[2];
      endcase
      return d;
   endfunction

endpackage

// File: rtl/tdes_round_counter.sv
// Per-pass round counter with terminal count and direction-aware key round index.
module tdes_round_counter
   import tdes_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clr,
   input  logic            i_en,
   input  logic            i_dec,
   output logic            o_tc,
   output logic [RN_W-1:0] o_round_number
);

   logic [CNT_W-1:0] r_count;

   // Clear wins over enable so a new pass always starts at round 0
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tc = (r_count == CNT_W'(NUM_ROUNDS - 1));

   // Decrypt passes walk the key schedule backwards
   assign o_round_number = i_dec ? RN_W'(CNT_W'(NUM_ROUNDS - 1) - r_count)
                                 : RN_W'(r_count);

endmodule

// File: rtl/tdes_round_scheduler.sv
// Triple-DES sequencer: steps a single-round DES datapath through three EDE passes.
module tdes_round_scheduler
   import tdes_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode_dec,
   input  logic              hold,
   output logic              busy,
   output logic              load_en,
   output logic              round_en,
   output logic              pass_end,
   output logic              done,
   output logic [RN_W-1:0]   round_number,
   output logic [KEY_W-1:0]  key_sel,
   output logic              pass_dec,
   output logic [PASS_W-1:0] pass_idx
);

   state_t              r_state;
   state_t              w_next_state;
   logic                r_load_en;
   logic                r_round_en;
   logic                r_pass_end;
   logic                r_done;
   logic                r_mode_dec;
   logic [PASS_W-1:0]   r_pass_idx;
   logic                w_load_en_nxt;
   logic                w_round_en_nxt;
   logic                w_pass_end_nxt;
   logic                w_done_nxt;
   logic                w_mode_dec_nxt;
   logic [PASS_W-1:0]   w_pass_idx_nxt;
   logic                w_cnt_clr;
   logic                w_cnt_en;
   logic                w_tc;
   logic                w_busy;
   logic                w_pass_dec;
   logic [KEY_W-1:0]    w_key_sel;
   logic [RN_W-1:0]     w_round_number;

   // State, strobes, captured mode and pass index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_load_en  <= 1'b0;
         r_round_en <= 1'b0;
         r_pass_end <= 1'b0;
         r_done     <= 1'b0;
         r_mode_dec <= 1'b0;
         r_pass_idx <= '0;
      end else begin
         r_state    <= w_next_state;
         r_load_en  <= w_load_en_nxt;
         r_round_en <= w_round_en_nxt;
         r_pass_end <= w_pass_end_nxt;
         r_done     <= w_done_nxt;
         r_mode_dec <= w_mode_dec_nxt;
         r_pass_idx <= w_pass_idx_nxt;
      end
   end

   // Next state; strobes are computed one edge early so hold never reaches an output directly
   always_comb begin
      w_next_state   = r_state;
      w_load_en_nxt  = 1'b0;
      w_round_en_nxt = 1'b0;
      w_pass_end_nxt = 1'b0;
      w_done_nxt     = 1'b0;
      w_mode_dec_nxt = r_mode_dec;
      w_pass_idx_nxt = r_pass_idx;
      w_cnt_clr      = 1'b0;
      w_cnt_en       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state   = ST_LOAD;
               w_mode_dec_nxt = mode_dec;
               w_pass_idx_nxt = '0;
               w_cnt_clr      = 1'b1;
               w_load_en_nxt  = 1'b1;
            end
         end
         ST_LOAD: begin
            w_next_state   = ST_ROUND;
            w_round_en_nxt = 1'b1;
         end
         ST_ROUND: begin
            if (!hold) begin
               if (w_tc) begin
                  w_next_state   = ST_PASS_END;
                  w_pass_end_nxt = 1'b1;
               end else begin
                  w_cnt_en       = 1'b1;
                  w_round_en_nxt = 1'b1;
               end
            end
         end
         ST_PASS_END: begin
            if (!hold) begin
               if (r_pass_idx != PASS_W'(NUM_PASSES - 1)) begin
                  w_next_state   = ST_ROUND;
                  w_pass_idx_nxt = r_pass_idx + PASS_W'(1);
                  w_cnt_clr      = 1'b1;
                  w_round_en_nxt = 1'b1;
               end else begin
                  w_next_state = ST_DONE;
                  w_done_nxt   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Schedule decode from the captured mode and current pass
   always_comb begin
      w_key_sel  = sched_key(r_mode_dec, r_pass_idx);
      w_pass_dec = sched_dec(r_mode_dec, r_pass_idx);
   end

   tdes_round_counter u_round_counter (
      .clk            (clk),
      .rst            (rst),
      .i_clr          (w_cnt_clr),
      .i_en           (w_cnt_en),
      .i_dec          (w_pass_dec),
      .o_tc           (w_tc),
      .o_round_number (w_round_number)
   );

   // Index outputs read zero while idle so a finished block leaves nothing on the bus
   assign w_busy       = (r_state != ST_IDLE);
   assign busy         = w_busy;
   assign load_en      = r_load_en;
   assign round_en     = r_round_en;
   assign pass_end     = r_pass_end;
   assign done         = r_done;
   assign round_number = w_busy ? w_round_number : '0;
   assign key_sel      = w_busy ? w_key_sel : '0;
   assign pass_dec     = w_busy & w_pass_dec;
   assign pass_idx     = w_busy ? r_pass_idx : '0;

endmodule

// File: tb/tb_tdes_round_scheduler.sv
// Self-checking bench for tdes_round_scheduler against a step-indexed block model.
module tb_tdes_round_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mode_dec = 1'b0;
   logic       hold = 1'b0;
   logic       busy, load_en, round_en, pass_end, done, pass_dec;
   logic [4:0] round_number;
   logic [1:0] key_sel;
   logic [1:0] pass_idx;

   int errors = 0;
   int checks = 0;

   // Model: a block is 53 steps (0 = load, 1..51 = 3 x (16 rounds + pass end), 52 = done)
   bit m_active = 1'b0;
   int m_k      = 0;
   bit m_held   = 1'b0;
   bit m_mode   = 1'b0;

   logic [14:0] obs;
   logic [14:0] exp_v;

   tdes_round_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode_dec     (mode_dec),
      .hold         (hold),
      .busy         (busy),
      .load_en      (load_en),
      .round_en     (round_en),
      .pass_end     (pass_end),
      .done         (done),
      .round_number (round_number),
      .key_sel      (key_sel),
      .pass_dec     (pass_dec),
      .pass_idx     (pass_idx)
   );

   always #5 clk = ~clk;

   // Expected output vector for the model's current cycle
   function automatic logic [14:0] model_out();
      int p, pos, key;
      bit rnd, pe, dir;
      p = 0; pos = 0; rnd = 1'b0; pe = 1'b0;
      if (!m_active) return '0;
      if (m_k == 52) begin
         p = 2; pos = 15;
      end else if (m_k > 0) begin
         p   = (m_k - 1) / 17;
         pos = (m_k - 1) % 17;
         if (pos == 16) begin
            pe = 1'b1; pos = 15;
         end else begin
            rnd = 1'b1;
         end
      end
      key = m_mode ? (2 - p) : p;
      dir = m_mode ? (p != 1) : (p == 1);
      return {1'b1, 1'(m_k == 0), rnd & ~m_held, pe & ~m_held, 1'(m_k == 52),
              5'(dir ? (15 - pos) : pos), 2'(key), dir, 2'(p)};
   endfunction

   // Apply inputs for one edge, advance the model, then sample just after the edge
   task automatic tick(input logic st, input logic md, input logic hd, input logic rs);
      start = st; mode_dec = md; hold = hd; rst = rs;
      @(posedge clk);
      if (rs) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1'b1; m_k = 0; m_held = 1'b0; m_mode = md;
         end
      end else if (m_k >= 1 && m_k <= 51 && hd) begin
         m_held = 1'b1;
      end else if (m_k == 52) begin
         m_active = 1'b0;
      end else begin
         m_k++; m_held = 1'b0;
      end
      #1;
      obs   = {busy, load_en, round_en, pass_end, done, round_number, key_sel, pass_dec, pass_idx};
      exp_v = model_out();
   endtask

   // Run one block from start to idle; hmode 0 = no hold, 1 = directed holds, 2 = random holds
   task automatic run_block(input bit md, input int hmode, output int done_at,
                            output int n_round, output int n_pe, output int stalls);
      int t;
      done_at = -1; n_round = 0; n_pe = 0; stalls = 0;
      tick(1'b1, md, 1'b0, 1'b0);
      t = 1;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL block_load cyc=%0d got=%h exp=%h", t, obs, exp_v);
      end
      while (m_active && t < 300) begin
         bit hd;
         if (hmode == 1)      hd = (t == 18 || t == 19 || t == 28 || t == 29 || t == 30);
         else if (hmode == 2) hd = ($urandom_range(3) == 0);
         else                 hd = 1'b0;
         if (hd && m_k >= 1 && m_k <= 51) stalls++;
         tick(1'b0, 1'($urandom), hd, 1'b0);
         t++;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_cycle cyc=%0d got=%h exp=%h", t, obs, exp_v);
         end
         if (done)     done_at = t;
         if (round_en) n_round++;
         if (pass_end) n_pe++;
      end
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 15'd0);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
         checks++;
         if (obs !== 15'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got=%h exp=%h", i, obs, 15'd0);
         end
      end
   endtask

   task automatic test_block(input bit md, input string name);
      int done_at, n_round, n_pe, stalls;
      run_block(md, 0, done_at, n_round, n_pe, stalls);
      checks++;
      if (done_at !== 53) begin
         errors++;
         $display("FAIL %s_done_cycle got=%0d exp=53", name, done_at);
      end
      checks++;
      if (n_round !== 48 || n_pe !== 3) begin
         errors++;
         $display("FAIL %s_strobe_count got rounds=%0d ends=%0d exp rounds=48 ends=3", name, n_round, n_pe);
      end
   endtask

   task automatic test_hold();
      int done_at, n_round, n_pe, stalls;
      run_block(1'b0, 1, done_at, n_round, n_pe, stalls);
      checks++;
      if (done_at !== 58) begin
         errors++;
         $display("FAIL hold_done_cycle got=%0d exp=58", done_at);
      end
      checks++;
      if (n_round !== 48 || n_pe !== 3) begin
         errors++;
         $display("FAIL hold_strobe_count got rounds=%0d ends=%0d exp rounds=48 ends=3", n_round, n_pe);
      end
   endtask

   task automatic test_random_hold();
      for (int b = 0; b < 4; b++) begin
         int done_at, n_round, n_pe, stalls;
         run_block(1'($urandom), 2, done_at, n_round, n_pe, stalls);
         checks++;
         if (done_at !== 53 + stalls || n_round !== 48 || n_pe !== 3) begin
            errors++;
            $display("FAIL rand_hold blk=%0d got done=%0d rounds=%0d ends=%0d exp done=%0d rounds=48 ends=3",
                     b, done_at, n_round, n_pe, 53 + stalls);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t;
      int dones[$];
      int loads[$];
      int d0, d1, l0, l1;
      t = 0;
      for (int i = 0; i < 120; i++) begin
         tick(1'b1, 1'($urandom), 1'b0, 1'b0);
         t++;
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_cycle cyc=%0d got=%h exp=%h", t, obs, exp_v);
         end
         if (done)    dones.push_back(t);
         if (load_en) loads.push_back(t);
      end
      for (int i = 0; i < 100 && m_active; i++) begin
         tick(1'b0, 1'($urandom), 1'b0, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_drain step=%0d got=%h exp=%h", i, obs, exp_v);
         end
      end
      d0 = (dones.size() > 0) ? dones[0] : -1;
      d1 = (dones.size() > 1) ? dones[1] : -1;
      l0 = (loads.size() > 0) ? loads[0] : -1;
      l1 = (loads.size() > 1) ? loads[1] : -1;
      checks++;
      if (d0 !== 53 || d1 !== 107) begin
         errors++;
         $display("FAIL b2b_done_cycles got=%0d,%0d exp=53,107", d0, d1);
      end
      checks++;
      if (l0 !== 1 || l1 !== 55) begin
         errors++;
         $display("FAIL b2b_load_cycles got=%0d,%0d exp=1,55", l0, l1);
      end
   endtask

   task automatic test_reset_mid();
      int done_seen, done_at, n_round, n_pe, stalls;
      done_seen = 0;
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 23; i++) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre got=%h exp=%h", obs, exp_v);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== 15'd0) begin
         errors++;
         $display("FAIL rst_mid_idle got=%h exp=%h", obs, 15'd0);
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
         if (done) done_seen++;
      end
      checks++;
      if (done_seen !== 0 || obs !== 15'd0) begin
         errors++;
         $display("FAIL rst_mid_no_done got dones=%0d out=%h exp dones=0 out=0", done_seen, obs);
      end
      run_block(1'($urandom), 0, done_at, n_round, n_pe, stalls);
      checks++;
      if (done_at !== 53) begin
         errors++;
         $display("FAIL rst_mid_restart_done got=%0d exp=53", done_at);
      end
   endtask

   initial begin
      test_reset();
      test_block(1'b0, "encrypt");
      test_block(1'b1, "decrypt");
      test_hold();
      test_random_hold();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
